register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
// - General-purpose register file of the simplified MIPS datapath.
// - Directly downstream of the RegDst 2:1 mux: the mux output drives waddr,
//   selecting rt (I-type) or rd (R-type) as the write destination.
// - Two combinational read ports feed the ALU operand path and the ALUSrc mux.
// - One synchronous write port, driven by the write-back stage.
// PARAMETERS
// - DATA_W  16  width of each register and of the data ports
// - ADDR_W  3   address width; the file holds 2**ADDR_W registers (8 by default)
// PORTS
// - clk    input   1       rising-edge clock
// - rst    input   1       asynchronous, active-high reset; clears all registers
// - we     input   1       write enable, sampled on the rising edge of clk
// - waddr  input   ADDR_W  write address, driven by the RegDst 2:1 mux output
// - wdata  input   DATA_W  write data
// - raddr1 input   ADDR_W  read port 1 address (rs)
// - raddr2 input   ADDR_W  read port 2 address (rt)
// - rdata1 output  DATA_W  read port 1 data
// - rdata2 output  DATA_W  read port 2 data
// BEHAVIOUR
// - Storage: regs[0 .. 2**ADDR_W-1], each DATA_W bits wide.
// - Reset
//   - rst high clears every register to 0 immediately, without waiting for clk.
//   - rst high on the same edge as a write: rst wins and the write is dropped.
//   - While rst is high, rdata1 and rdata2 read 0.
// - Write
//   - On posedge clk with rst=0, we=1 and waddr!=0: regs[waddr] <= wdata.
//   - we=0 leaves every register unchanged.
//   - Latency: the new value is visible on the read ports after the edge
//     (same cycle only when MIPS_RF_BYPASS_EN is defined).
// - Register 0
//   - Hardwired to 0; writes to address 0 are silently ignored.
//   - A read of address 0 returns 0 in every mode, including during a bypass.
// - Read
//   - Combinational: rdata1 = regs[raddr1] and rdata2 = regs[raddr2].
//   - There is no read latency.
//   - Both ports may read the same address at the same time.
// - Width rules
//   - No sign extension or truncation; wdata is stored bit-exact.
//   - Every waddr value is in range, because the depth is 2**ADDR_W.
// - No X propagation: all registers are defined from reset onward.
// CONFIGURATION
// - MIPS_RF_BYPASS_EN defined (write-through forwarding)
//   - Applies when we=1, waddr!=0 and raddrN==waddr.
//   - Under those conditions rdataN = wdata combinationally, in the same cycle.
//   - Applies to each port independently.
// - MIPS_RF_BYPASS_EN undefined
//   - rdataN returns the stored (old) value until the write edge.
//   - rdataN returns the new value after that edge.
// TESTING
// - Reset: write 16'h1234 to r3, then pulse rst mid-cycle -> rdata1 (raddr1=3)
//   reads 0 before the next clk edge.
// - Basic write/read: we=1, waddr=5, wdata=16'hBEEF, edge -> raddr1=5 gives
//   16'hBEEF; raddr2=4 gives 0.
// - r0 protection: we=1, waddr=0, wdata=16'hFFFF, edge -> raddr1=0 and
//   raddr2=0 both give 16'h0000.
// - Dual read with write hold: r1=16'h0001, r2=16'h0002, then we=0 with
//   wdata=16'hAAAA for 3 edges -> rdata1=1 and rdata2=2 throughout.
// - Same-cycle read of a write target: r6=16'h00AA, then we=1, waddr=6,
//   wdata=16'h5555, raddr1=6, sampled before the edge:
//   - bypass defined -> 16'h5555.
//   - bypass undefined -> 16'h00AA.
//   - After the edge -> 16'h5555 in both modes.
// - Reset vs write collision: rst=1 on the edge where we=1, waddr=7,
//   wdata=16'h7777 -> r7 reads 0 after rst is released.

Source files
------------

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : General-purpose register file for the simplified MIPS
//               datapath. It has two combinational read ports (rs and rt)
//               and one synchronous write port. The write address comes
//               from the RegDst mux. Register 0 always reads as zero.
// Optional    : Define MIPS_RF_BYPASS_EN to enable write-through
//               forwarding. When it is defined, a read port whose address
//               matches an active write shows wdata in the same cycle.
// Ports       : clk    - rising-edge clock
//               rst    - asynchronous active-high reset; clears every register
//               we     - write enable, sampled on the rising edge of clk
//               waddr  - write address (RegDst mux output)
//               wdata  - write data
//               raddr1 - read port 1 address (rs)
//               raddr2 - read port 2 address (rt)
//               rdata1 - read port 1 data
//               rdata2 - read port 2 data
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // A write to address 0 is dropped here. Because of that, regs[0] keeps
  // the zero it gets at reset and never needs any separate storage logic.
  logic write_ok;
  assign write_ok = we && (waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Forwarding hit flags for each port. When bypass is not built in, both
  // flags are tied low and each read port shows only the stored value.
  logic bypass1;
  logic bypass2;

`ifdef MIPS_RF_BYPASS_EN
  assign bypass1 = write_ok && (raddr1 == waddr);
  assign bypass2 = write_ok && (raddr2 == waddr);
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  // The outputs are forced to zero while rst is high. The registers are
  // already clear by then, but forcing them also hides the forwarding path,
  // so a read during reset is always zero. Address 0 is forced to zero here
  // as well, which keeps it zero even when a bypass would otherwise apply.
  assign rdata1 = (rst || (raddr1 == '0)) ? '0 :
                  bypass1                 ? wdata :
                                            regs[raddr1];

  assign rdata2 = (rst || (raddr2 == '0)) ? '0 :
                  bypass2                 ? wdata :
                                            regs[raddr2];

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed, self-checking bench for register_file. It covers
//               reset, basic write and read, r0 protection, write hold,
//               same-cycle read of a write target, and a reset/write
//               collision. Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic [15:0] rdata1;
  logic [15:0] rdata2;

  int checks   = 0;
  int failures = 0;

  register_file #(
    .DATA_W(16),
    .ADDR_W(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    we     = 1'b0;
    waddr  = 3'd0;
    wdata  = 16'h0000;
    raddr1 = 3'd3;
    raddr2 = 3'd5;
    #1;
    check("reset_rdata1", rdata1, 16'h0000);
    check("reset_rdata2", rdata2, 16'h0000);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_reset_rdata1", rdata1, 16'h0000);

    // Reset clears r3 asynchronously, mid-cycle.
    write_reg(3'd3, 16'h1234);
    raddr1 = 3'd3;
    #1;
    check("r3_written", rdata1, 16'h1234);
    #1;
    rst = 1'b1;
    #1;
    check("r3_during_async_rst", rdata1, 16'h0000);
    rst = 1'b0;
    #1;
    check("r3_after_async_rst", rdata1, 16'h0000);

    // Basic write and read.
    write_reg(3'd5, 16'hBEEF);
    raddr1 = 3'd5;
    raddr2 = 3'd4;
    #1;
    check("basic_r5", rdata1, 16'hBEEF);
    check("basic_r4", rdata2, 16'h0000);

    // Writes to r0 are ignored, both before and after the edge.
    we     = 1'b1;
    waddr  = 3'd0;
    wdata  = 16'hFFFF;
    raddr1 = 3'd0;
    raddr2 = 3'd0;
    #1;
    check("r0_pre_edge", rdata1, 16'h0000);
    step();
    we = 1'b0;
    #1;
    check("r0_port1", rdata1, 16'h0000);
    check("r0_port2", rdata2, 16'h0000);

    // Dual read while writes are held off.
    write_reg(3'd1, 16'h0001);
    write_reg(3'd2, 16'h0002);
    we     = 1'b0;
    waddr  = 3'd1;
    wdata  = 16'hAAAA;
    raddr1 = 3'd1;
    raddr2 = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_r1", rdata1, 16'h0001);
      check("hold_r2", rdata2, 16'h0002);
    end

    // Both ports read the same address.
    raddr2 = 3'd1;
    #1;
    check("same_addr_port2", rdata2, 16'h0001);

    // Same-cycle read of a write target.
    write_reg(3'd6, 16'h00AA);
    we     = 1'b1;
    waddr  = 3'd6;
    wdata  = 16'h5555;
    raddr1 = 3'd6;
    raddr2 = 3'd5;
    #1;
`ifdef MIPS_RF_BYPASS_EN
    check("r6_pre_edge", rdata1, 16'h5555);
`else
    check("r6_pre_edge", rdata1, 16'h00AA);
`endif
    check("other_port_unaffected", rdata2, 16'hBEEF);
    step();
    we = 1'b0;
    #1;
    check("r6_post_edge", rdata1, 16'h5555);

    // Reset wins over a write on the same edge.
    we    = 1'b1;
    waddr = 3'd7;
    wdata = 16'h7777;
    #2;
    rst = 1'b1;
    step();
    rst    = 1'b0;
    we     = 1'b0;
    raddr1 = 3'd7;
    raddr2 = 3'd5;
    #1;
    check("r7_collision", rdata1, 16'h0000);
    check("r5_cleared", rdata2, 16'h0000);

    // The register file accepts writes again once reset is released.
    write_reg(3'd7, 16'h7777);
    #1;
    check("r7_after_recovery", rdata1, 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
